step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//  Multi-track, parameterised beat sequencer; successor to the single-track 16-step composer.
//  Holds a per-track on/off pattern for each step and advances through the steps at a programmable tempo.
//  Generates a square-wave tone for every track whose pattern bit is set on the current step.
//  Sits between the switch/key input layer and the GPIO speaker pins.
// PARAMETERS
//  NUM_TRACKS  4    number of independent tracks (voices)
//  NUM_STEPS   16   steps per pattern; power of two, >=2
//  PERIOD_W    26   width of step_period (CLOCK_50 cycles per step)
//  TONE_W      16   width of each track's tone half-period
//  Derived: STEP_W = $clog2(NUM_STEPS), TRK_W = max(1,$clog2(NUM_TRACKS))
// PORTS
//  CLOCK_50      in   1                  system clock; all logic on its rising edge
//  reset         in   1                  asynchronous, active-high
//  start         in   1                  1-cycle pulse: IDLE->PLAY, or PAUSE->PLAY
//  stop          in   1                  1-cycle pulse: any state ->IDLE
//  pause         in   1                  1-cycle pulse: PLAY->PAUSE
//  load_en       in   1                  write load_pattern into track load_track
//  load_track    in   TRK_W              target track of write; values >=NUM_TRACKS ignored
//  load_pattern  in   NUM_STEPS          bit s = track sounds on step s
//  step_period   in   PERIOD_W           cycles per step; 0 treated as 1
//  tone_half     in   NUM_TRACKS*TONE_W  per-track tone half-period, track t at [t*TONE_W +: TONE_W]
//  loop_len      in   STEP_W             last step index (only with STEP_SEQ_LOOP_EN)
//  current_step  out  STEP_W             step being played
//  step_tick     out  1                  1-cycle pulse when a step begins
//  playing       out  1                  high in PLAY
//  note_on       out  NUM_TRACKS         pattern[t][current_step] && playing
//  spk_out       out  NUM_TRACKS         per-track square wave
//  spk_mix       out  1                  OR of spk_out
// BEHAVIOUR
//  Reset: state IDLE; pattern memory, current_step, period/tone counters, all outputs 0.
//  FSM IDLE/PLAY/PAUSE; same-cycle priority stop > pause > start.
//   IDLE: start -> PLAY. First PLAY cycle: current_step=0, step_tick=1, period counter=0.
//   PLAY: period counter 0..P-1 (P = max(step_period,1)); on P-1 it clears.
//    Same edge: current_step increments and step_tick pulses the next cycle.
//    current_step wraps from last step to 0.
//    step_period is sampled at each step boundary; a mid-step change does not alter the current step.
//   pause -> PAUSE: period counter and current_step frozen; note_on, spk_out = 0.
//   PAUSE: start -> PLAY; resume mid-step from frozen count, no step_tick.
//   stop: -> IDLE; current_step, counters cleared next cycle.
//  Registers: all outputs registered; note_on, spk_out reflect state/step one cycle after the update.
//  Load: load_en writes that track's row in any state.
//   Write to current step is visible on note_on the next cycle.
//   Simultaneous load and step advance: new row and new step both apply.
//  Tone, per track t:
//   While note_on[t]=1: counter counts 0..H-1 (H = tone_half[t]); at H-1 counter clears, spk_out[t] toggles.
//   If H=0, spk_out[t] is held 0.
//   When note_on[t] falls: counter and spk_out[t] return to 0 next cycle.
//   Consecutive active steps keep the phase continuous (no restart).
//  Width: counters compare with ==, no overflow wrap past P-1/H-1.
// CONFIGURATION
//  STEP_SEQ_LOOP_EN defined:
//   Wrap occurs after step loop_len (sampled at each boundary).
//   If current_step > loop_len at a boundary, next step is 0.
//  STEP_SEQ_LOOP_EN undefined:
//   No loop_len port; wrap after NUM_STEPS-1.
// TESTING
//  T1 reset mid-PLAY -> all outputs 0, pattern cleared, IDLE within 0 edges (async).
//  T2 step_period=4, start -> step_tick every 4 cycles; current_step 0..15 then 0 after 64 cycles.
//  T3 track0 pattern=16'h0001, tone_half=3, P=20 ->
//     spk_out[0] toggles every 3 cycles during step 0 only; 0 during steps 1..15.
//  T4 pause at step 5 count 2, hold 10 cycles, start ->
//     outputs muted while paused; step 6 begins P-3 cycles after resume; no extra tick.
//  T5 stop+pause+start same cycle in PLAY -> IDLE; load track 1 during step 3 with bit3=1 ->
//     note_on[1]=1 next cycle.
//  T6 (STEP_SEQ_LOOP_EN) loop_len=3 -> steps 0,1,2,3,0; change to 1 while at step 3 -> next step 0.

Source files
------------

// File: rtl/step_sequencer.sv
// Multi-track step sequencer: per-track step patterns, programmable tempo, per-track square-wave tones.
// Optional STEP_SEQ_LOOP_EN adds a loop_len port that sets the last step index of the pattern.
module step_sequencer #(
  parameter int NUM_TRACKS = 4,
  parameter int NUM_STEPS  = 16,
  parameter int PERIOD_W   = 26,
  parameter int TONE_W     = 16,
  parameter int STEP_W     = $clog2(NUM_STEPS),
  parameter int TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         pause,
  input  logic                         load_en,
  input  logic [TRK_W-1:0]             load_track,
  input  logic [NUM_STEPS-1:0]         load_pattern,
  input  logic [PERIOD_W-1:0]          step_period,
  input  logic [NUM_TRACKS*TONE_W-1:0] tone_half,
`ifdef STEP_SEQ_LOOP_EN
  input  logic [STEP_W-1:0]            loop_len,
`endif
  output logic [STEP_W-1:0]            current_step,
  output logic                         step_tick,
  output logic                         playing,
  output logic [NUM_TRACKS-1:0]        note_on,
  output logic [NUM_TRACKS-1:0]        spk_out,
  output logic                         spk_mix
);

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;

  state_t                              state, state_next;
  logic [PERIOD_W-1:0]                 period_cnt, period_cnt_next;
  logic [PERIOD_W-1:0]                 period_len, period_len_next, period_sample;
  logic [STEP_W-1:0]                   step_next;
  logic                                advance, restart, boundary, step_last, tick_next;
  logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] pattern, row_next;
  logic [NUM_TRACKS-1:0]               note_next, spk_next;

  assign period_sample = (step_period == '0) ? PERIOD_W'(1) : step_period;
  assign boundary      = advance && (period_cnt == period_len - PERIOD_W'(1));
  assign tick_next     = restart || boundary;

`ifdef STEP_SEQ_LOOP_EN
  assign step_last = (current_step >= loop_len);
`else
  assign step_last = (current_step == STEP_W'(NUM_STEPS - 1));
`endif

  // The resume edge out of PAUSE counts like a PLAY edge, so every step spans P playing cycles.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    restart    = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else if (pause) begin
      if (state == PLAY) state_next = PAUSE;
    end else if (start && state == IDLE) begin
      state_next = PLAY;
      restart    = 1'b1;
    end else if (start && state == PAUSE) begin
      state_next = PLAY;
      advance    = 1'b1;
    end else if (state == PLAY) begin
      advance = 1'b1;
    end
  end

  always_comb begin
    step_next       = current_step;
    period_cnt_next = period_cnt;
    period_len_next = period_len;
    if (stop) begin
      step_next       = '0;
      period_cnt_next = '0;
    end else if (restart) begin
      step_next       = '0;
      period_cnt_next = '0;
      period_len_next = period_sample;
    end else if (boundary) begin
      step_next       = step_last ? '0 : current_step + STEP_W'(1);
      period_cnt_next = '0;
      period_len_next = period_sample;
    end else if (advance) begin
      period_cnt_next = period_cnt + PERIOD_W'(1);
    end
  end

  // note_on is built from next-state values so a load and a step change land on the same edge.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_TRACKS; gi++) begin : g_track
      logic [TONE_W-1:0] half;
      logic [TONE_W-1:0] cnt, cnt_next;
      logic              spk, spk_nx;

      assign row_next[gi]  = (load_en && load_track == TRK_W'(gi)) ? load_pattern : pattern[gi];
      assign note_next[gi] = (state_next == PLAY) && row_next[gi][step_next];
      assign half          = tone_half[gi*TONE_W +: TONE_W];

      always_comb begin
        cnt_next = cnt;
        spk_nx   = spk;
        if (!note_on[gi] || !note_next[gi] || half == '0) begin
          cnt_next = '0;
          spk_nx   = 1'b0;
        end else if (cnt == half - TONE_W'(1)) begin
          cnt_next = '0;
          spk_nx   = ~spk;
        end else begin
          cnt_next = cnt + TONE_W'(1);
        end
      end

      always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
          cnt <= '0;
          spk <= 1'b0;
        end else begin
          cnt <= cnt_next;
          spk <= spk_nx;
        end
      end

      assign spk_next[gi] = spk_nx;
      assign spk_out[gi]  = spk;
    end
  endgenerate

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      period_cnt   <= '0;
      period_len   <= '0;
      current_step <= '0;
      step_tick    <= 1'b0;
      playing      <= 1'b0;
      note_on      <= '0;
      spk_mix      <= 1'b0;
      pattern      <= '0;
    end else begin
      state        <= state_next;
      period_cnt   <= period_cnt_next;
      period_len   <= period_len_next;
      current_step <= step_next;
      step_tick    <= tick_next;
      playing      <= (state_next == PLAY);
      note_on      <= note_next;
      spk_mix      <= |spk_next;
      pattern      <= row_next;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: a cycle-level behavioural model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_step_sequencer;

  localparam int NT = 4;
  localparam int NS = 16;
  localparam int IDLE_S = 0, PLAY_S = 1, PAUSE_S = 2;

  logic        clk;
  logic        reset, start, stop, pause, load_en;
  logic [1:0]  load_track;
  logic [15:0] load_pattern;
  logic [25:0] step_period;
  logic [63:0] tone_half;
`ifdef STEP_SEQ_LOOP_EN
  logic [3:0]  loop_len;
`endif
  logic [3:0]  current_step;
  logic        step_tick, playing, spk_mix;
  logic [3:0]  note_on, spk_out;

  int n_cmp = 0;
  int n_bad = 0;

  step_sequencer dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .load_en(load_en), .load_track(load_track), .load_pattern(load_pattern),
    .step_period(step_period), .tone_half(tone_half),
`ifdef STEP_SEQ_LOOP_EN
    .loop_len(loop_len),
`endif
    .current_step(current_step), .step_tick(step_tick), .playing(playing),
    .note_on(note_on), .spk_out(spk_out), .spk_mix(spk_mix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: state, step and elapsed cycles within the step; tone phase from note age.
  int          m_state, m_step, m_el, m_len, m_tick, sp, last, h;
  int          m_age [NT];
  logic [15:0] m_pat [NT];
  logic [3:0]  m_note, m_spk, prev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = IDLE_S; m_step = 0; m_el = 0; m_len = 1; m_tick = 0;
      m_note = '0; m_spk = '0;
      for (int t = 0; t < NT; t++) begin m_pat[t] = '0; m_age[t] = 0; end
    end else begin
      prev = m_note;
      if (load_en && int'(load_track) < NT) m_pat[load_track] = load_pattern;
      sp = (step_period == 0) ? 1 : int'(step_period);
`ifdef STEP_SEQ_LOOP_EN
      last = int'(loop_len);
`else
      last = NS - 1;
`endif
      m_tick = 0;
      if (stop) begin
        m_state = IDLE_S; m_step = 0; m_el = 0;
      end else if (pause) begin
        if (m_state == PLAY_S) m_state = PAUSE_S;
      end else if (start && m_state == IDLE_S) begin
        m_state = PLAY_S; m_step = 0; m_el = 0; m_len = sp; m_tick = 1;
      end else if (m_state == PLAY_S || (start && m_state == PAUSE_S)) begin
        m_state = PLAY_S;
        if (m_el == m_len - 1) begin
          m_el = 0; m_len = sp; m_tick = 1;
          m_step = (m_step >= last) ? 0 : m_step + 1;
        end else begin
          m_el++;
        end
      end
      for (int t = 0; t < NT; t++) begin
        m_note[t] = (m_state == PLAY_S) && m_pat[t][m_step];
        m_age[t]  = (m_note[t] && prev[t]) ? m_age[t] + 1 : 0;
        h = int'(tone_half[t*16 +: 16]);
        m_spk[t] = m_note[t] && (h != 0) && (((m_age[t] / h) % 2) == 1);
      end
    end
  end

  logic [14:0] act_v, exp_v;
  always @(negedge clk) begin
    if (!reset) begin
      act_v = {current_step, step_tick, playing, note_on, spk_out, spk_mix};
      exp_v = {4'(m_step), m_tick[0], (m_state == PLAY_S), m_note, m_spk, |m_spk};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL model_cycle t=%0t: got %h expected %h", $time, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_stop;
    stop = 1'b1; @(negedge clk); stop = 1'b0;
  endtask

  task automatic load(input int trk, input logic [15:0] p);
    load_en = 1'b1; load_track = 2'(trk); load_pattern = p;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  logic [39:0] cap;
  int          ticks;
  logic [19:0] steps_seen;

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; load_en = 1'b0;
    load_track = '0; load_pattern = '0; step_period = 26'd4;
    tone_half = {16'd2, 16'd0, 16'd5, 16'd3};
`ifdef STEP_SEQ_LOOP_EN
    loop_len = 4'd15;
`endif
    #1 reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    check("reset_outputs", {current_step, step_tick, playing, note_on, spk_out, spk_mix}, 0);

    // T2: P=4, one tick every 4 cycles, wrap to step 0 after 64 cycles
    pulse_start;
    check("t2_first_cycle", {step_tick, playing, current_step}, {1'b1, 1'b1, 4'd0});
    ticks = 0;
    repeat (64) begin @(negedge clk); ticks += int'(step_tick); end
    check("t2_tick_count", ticks, 16);
    check("t2_wrap_step", {step_tick, current_step}, {1'b1, 4'd0});
    pulse_stop;
    check("t2_stop_idle", {playing, current_step}, {1'b0, 4'd0});

    // T3: track0 on step 0 only, half-period 3, P=20
    load(0, 16'h0001);
    step_period = 26'd20;
    pulse_start;
    check("t3_note_on", note_on, 4'b0001);
    for (int k = 0; k < 40; k++) begin cap[k] = spk_out[0]; @(negedge clk); end
    check("t3_spk0_wave", cap, 40'h00_0003_8E38);
    pulse_stop;

    // T4: pause in step 5 at count 2, hold 10 cycles, resume
    step_period = 26'd8;
    load(1, 16'hFFFF); load(2, 16'hFFFF); load(3, 16'hFFFF);
    pulse_start;
    cyc(42);
    check("t4_pre_pause_step", current_step, 4'd5);
    pause = 1'b1; @(negedge clk); pause = 1'b0;
    check("t4_paused_muted", {playing, note_on, spk_out, current_step}, {1'b0, 4'd0, 4'd0, 4'd5});
    cyc(9);
    pulse_start;
    check("t4_resume", {step_tick, playing, current_step}, {1'b0, 1'b1, 4'd5});
    cyc(4);
    check("t4_still_step5", current_step, 4'd5);
    cyc(1);
    check("t4_step6_tick", {step_tick, current_step}, {1'b1, 4'd6});
    pulse_stop;

    // T5: stop+pause+start together, then loads during play
    load(1, 16'h0000); load(2, 16'h0000);
    step_period = 26'd4;
    pulse_start;
    cyc(2);
    stop = 1'b1; pause = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    check("t5_all_three_idle", {playing, step_tick, current_step}, {1'b0, 1'b0, 4'd0});
    pulse_start;
    cyc(12);
    check("t5_step3_before_load", {current_step, note_on[1]}, {4'd3, 1'b0});
    load(1, 16'h0008);
    check("t5_load_visible", note_on[1], 1'b1);
    cyc(2);
    load(2, 16'h0010);
    check("t5_load_and_advance", {step_tick, current_step, note_on[2:1]}, {1'b1, 4'd4, 2'b10});
    pulse_stop;

    // step_period 0 behaves as 1
    step_period = 26'd0;
    pulse_start;
    cyc(3);
    check("p0_every_cycle", {step_tick, current_step}, {1'b1, 4'd3});
    pulse_stop;

`ifdef STEP_SEQ_LOOP_EN
    // T6: loop_len=3 then shrink to 1 while at step 3
    step_period = 26'd2;
    loop_len = 4'd3;
    pulse_start;
    for (int i = 0; i < 5; i++) begin steps_seen[i*4 +: 4] = current_step; cyc(2); end
    check("t6_loop_steps", steps_seen, 20'h03210);
    cyc(4);
    check("t6_at_step3", current_step, 4'd3);
    loop_len = 4'd1;
    cyc(2);
    check("t6_shrink_wrap", current_step, 4'd0);
    pulse_stop;
    loop_len = 4'd15;
`endif

    // T1: asynchronous reset mid-PLAY clears outputs and patterns
    step_period = 26'd4;
    load(1, 16'hFFFF);
    pulse_start;
    cyc(5);
    #2 reset = 1'b1;
    #1 check("t1_async_reset", {current_step, step_tick, playing, note_on, spk_out, spk_mix}, 0);
    @(negedge clk);
    reset = 1'b0;
    pulse_start;
    check("t1_pattern_cleared", {playing, note_on}, {1'b1, 4'd0});
    cyc(3);
    check("t1_pattern_cleared_later", note_on, 4'd0);
    pulse_stop;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
